// File: rtl/slot_sync_fifo.sv
`default_nettype none
// ============================================================================
// slot_sync_fifo : FIFO that commits writes only in write slots and returns
//                  data only in read slots, with sticky strobe-protocol checks.
// Revision       : 1.0
// ============================================================================
module slot_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err_overlap,
  output logic              err_order,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXP_READ  = 2'd1,
    EXP_WRITE = 2'd2
  } phase_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              err_overlap_q, err_overlap_d;
  logic              err_order_q, err_order_d;
  logic              err_overflow_q, err_overflow_d;
  phase_t            phase_q, phase_d;

  logic wslot, rslot, do_write, do_read;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    wslot          = write_en & ~read_en;
    rslot          = read_en & ~write_en;
    do_write       = wslot & in_valid & ~full;
    do_read        = rslot & ~empty;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    count_d        = count_q;
    out_data_d     = out_data_q;
    out_valid_d    = do_read;
    err_overlap_d  = err_overlap_q | (write_en & read_en);
    err_overflow_d = err_overflow_q | (wslot & in_valid & full);
    err_order_d    = err_order_q;
    phase_d        = phase_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_write) begin
      wptr_d  = wptr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (do_read) begin
      rptr_d     = rptr_q + ADDR_W'(1);
      count_d    = count_q - (ADDR_W+1)'(1);
      out_data_d = mem[rptr_q];
    end

    // Alternation tracking follows slots regardless of whether data moved.
    case (phase_q)
      IDLE: begin
        if (wslot)      phase_d = EXP_READ;
        else if (rslot) err_order_d = 1'b1;
      end
      EXP_READ: begin
        if (rslot)      phase_d = EXP_WRITE;
        else if (wslot) err_order_d = 1'b1;
      end
      EXP_WRITE: begin
        if (wslot)      phase_d = EXP_READ;
        else if (rslot) err_order_d = 1'b1;
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      err_overlap_q  <= 1'b0;
      err_order_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      phase_q        <= IDLE;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      err_overlap_q  <= err_overlap_d;
      err_order_q    <= err_order_d;
      err_overflow_q <= err_overflow_d;
      phase_q        <= phase_d;
    end
  end

  // Storage is not reset; the write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && do_write) mem[wptr_q] <= in_data;
  end

  assign in_ready     = wslot & ~full;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign count        = count_q;
  assign err_overlap  = err_overlap_q;
  assign err_order    = err_order_q;
  assign err_overflow = err_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_slot_sync_fifo : self-checking bench for slot_sync_fifo (queue model).
// Revision          : 1.0
// ============================================================================
module tb_slot_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              err_overlap;
  logic              err_order;
  logic              err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  slot_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .read_en      (read_en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err_overlap  (err_overlap),
    .err_order    (err_order),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words, the last legal slot kind and sticky flags.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_out_data;
  logic              m_out_valid;
  logic              m_ovl, m_ord, m_ovf;
  int                m_last;  // 0 none yet, 1 write, 2 read

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_out_data  = '0;
        m_out_valid = 1'b0;
        m_ovl       = 1'b0;
        m_ord       = 1'b0;
        m_ovf       = 1'b0;
        m_last      = 0;
      end else begin
        m_out_valid = 1'b0;
        if (write_en && read_en) begin
          m_ovl = 1'b1;
        end else if (write_en) begin
          if (m_last == 1) m_ord = 1'b1;
          else             m_last = 1;
          if (in_valid) begin
            if (mq.size() < DEPTH) mq.push_back(in_data);
            else                   m_ovf = 1'b1;
          end
        end else if (read_en) begin
          if (m_last != 1) m_ord = 1'b1;
          else             m_last = 2;
          if (mq.size() > 0) begin
            m_out_data  = mq.pop_front();
            m_out_valid = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison, mid-way through the low phase after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("in_ready", 32'(in_ready), 32'(write_en && !read_en && (mq.size() < DEPTH)));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(m_out_valid));
      chk("out_data", 32'(out_data), 32'(m_out_data));
      chk("err_overlap", 32'(err_overlap), 32'(m_ovl));
      chk("err_order", 32'(err_order), 32'(m_ord));
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    end
  end

  task automatic drive(input logic w, input logic r, input logic v, input logic [DATA_W-1:0] d);
    @(negedge clk);
    write_en = w;
    read_en  = r;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Generator-style periods carrying 0xA5.
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b0, 1'b1, 8'hA5);
      #1 chk("gen_ready_w", 32'(in_ready), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 8'hA5);
      #1 chk("gen_ready_r", 32'(in_ready), 32'd0);
      settle();
      chk("gen_out_valid", 32'(out_valid), 32'd1);
      chk("gen_out_data", 32'(out_data), 32'hA5);
      chk("gen_count", 32'(count), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 8'hA5);
      drive(1'b0, 1'b0, 1'b1, 8'hA5);
    end
    chk("gen_errs", 32'({err_overlap, err_order, err_overflow}), 32'd0);

    // Fill to full, overflow, then drain with wrap.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(i));
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    settle();
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 8'h09);
    #1 chk("ovf_ready", 32'(in_ready), 32'd0);
    settle();
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      settle();
      chk("drain_data", 32'(out_data), 32'(i));
      chk("drain_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    settle();
    chk("drain_empty", 32'(empty), 32'd1);

    // Read slot on empty FIFO.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    chk("rdempty_valid", 32'(out_valid), 32'd0);
    chk("rdempty_data", 32'(out_data), 32'h08);
    chk("rdempty_count", 32'(count), 32'd0);

    // Overlapping strobes with one stored word.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    settle();
    chk("ovl_flag", 32'(err_overlap), 32'd1);
    chk("ovl_count", 32'(count), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    chk("ovl_read", 32'(out_data), 32'h3C);
    chk("ovl_order", 32'(err_order), 32'd0);

    // Back-to-back write slots; flag must persist.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 1'b1, 8'h22);
    settle();
    chk("ord_flag", 32'(err_order), 32'd1);
    chk("ord_count", 32'(count), 32'd2);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    chk("ord_sticky", 32'(err_order), 32'd1);
    chk("ord_data", 32'(out_data), 32'h22);

    // Asynchronous reset mid-period with three words stored.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h03);
    settle();
    chk("arst_pre_count", 32'(count), 32'd3);
    #1;
    write_en = 1'b0;
    rst      = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_errs", 32'({err_overlap, err_order, err_overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    chk("arst_first_read_order", 32'(err_order), 32'd1);

    // Randomized slot traffic, mostly generator-shaped with occasional faults.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic w, r, v;
      w = ((i % 4) == 0);
      r = ((i % 4) == 1) && ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      if (i == 300) do_reset();
      drive(w, r, v, 8'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
